// File: rtl/cpu_loader.sv
// Host-side load/run/readback sequencer for the cpu memory backdoor ports.
// Define CPU_LOADER_READBACK_EN to build the data-memory readback (DUMP) path.
module cpu_loader #(
    parameter int CNT_W = 16,
    parameter int RUN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] imem_words,
    input  logic [CNT_W-1:0] dmem_words,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [63:0]      s_data,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [3:0] {
        IDLE, LOAD_I, LOAD_D, SETTLE, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_imem_n;
    logic [CNT_W-1:0] r_dmem_n;
    logic [RUN_W-1:0] r_run_n;
    logic [RUN_W-1:0] r_run_cnt;
    logic             r_s_ready;
    logic             r_wen;
    logic [63:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_wen2;
    logic [63:0]      r_addr2;
    logic [63:0]      r_wdata2;
    logic             r_cpu_en;
    logic             r_busy;
    logic             r_done;

    logic             w_hs;
    logic [CNT_W-1:0] w_k_inc;
    logic             w_last_i;
    logic             w_last_d;
    logic [63:0]      w_addr_i;
    logic [63:0]      w_addr_d;

    // k+1 never overflows CNT_W because k < count while a phase is active
    assign w_hs     = s_valid & r_s_ready;
    assign w_k_inc  = r_k + CNT_W'(1);
    assign w_last_i = (w_k_inc == r_imem_n);
    assign w_last_d = (w_k_inc == r_dmem_n);
    assign w_addr_i = 64'(r_k) << 2;
    assign w_addr_d = 64'(r_k) << 3;

`ifdef CPU_LOADER_READBACK_EN
    logic        r_ren2;
    logic        r_m_valid;
    logic [63:0] r_m_data;
    logic [63:0] w_addr_d_next;
    logic        w_unused;

    assign w_addr_d_next = 64'(w_k_inc) << 3;
    assign w_unused      = ^rdata_ext;
`else
    logic w_unused;

    assign w_unused = ^{rdata_ext, rdata_ext_2, m_ready};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_imem_n  <= '0;
            r_dmem_n  <= '0;
            r_run_n   <= '0;
            r_run_cnt <= '0;
            r_s_ready <= 1'b0;
            r_wen     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen2    <= 1'b0;
            r_addr2   <= '0;
            r_wdata2  <= '0;
            r_cpu_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef CPU_LOADER_READBACK_EN
            r_ren2    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
`endif
        end else begin
            // Memory strobes are single-cycle pulses unless re-armed below
            r_wen  <= 1'b0;
            r_wen2 <= 1'b0;
`ifdef CPU_LOADER_READBACK_EN
            r_ren2 <= 1'b0;
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_imem_n <= imem_words;
                        r_dmem_n <= dmem_words;
                        r_run_n  <= run_cycles;
                        r_k      <= '0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        if (imem_words != '0) begin
                            r_state   <= LOAD_I;
                            r_s_ready <= 1'b1;
                        end else if (dmem_words != '0) begin
                            r_state   <= LOAD_D;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                LOAD_I: begin
                    if (w_hs) begin
                        r_wen   <= 1'b1;
                        r_addr  <= w_addr_i;
                        r_wdata <= s_data[31:0];
                        if (w_last_i) begin
                            r_k <= '0;
                            if (r_dmem_n != '0) begin
                                r_state <= LOAD_D;
                            end else begin
                                r_state   <= SETTLE;
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_k <= w_k_inc;
                        end
                    end
                end
                LOAD_D: begin
                    if (w_hs) begin
                        r_wen2   <= 1'b1;
                        r_addr2  <= w_addr_d;
                        r_wdata2 <= s_data;
                        if (w_last_d) begin
                            r_k       <= '0;
                            r_state   <= SETTLE;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_k <= w_k_inc;
                        end
                    end
                end
                SETTLE: begin
                    if (r_run_n != '0) begin
                        r_state   <= RUN;
                        r_cpu_en  <= 1'b1;
                        r_run_cnt <= r_run_n;
                    end else
`ifdef CPU_LOADER_READBACK_EN
                    if (r_dmem_n != '0) begin
                        r_state <= DUMP_RD;
                        r_ren2  <= 1'b1;
                        r_addr2 <= '0;
                    end else
`endif
                    begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_run_cnt == RUN_W'(1)) begin
                        r_cpu_en <= 1'b0;
                        r_k      <= '0;
`ifdef CPU_LOADER_READBACK_EN
                        if (r_dmem_n != '0) begin
                            r_state <= DUMP_RD;
                            r_ren2  <= 1'b1;
                            r_addr2 <= '0;
                        end else
`endif
                        begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_run_cnt <= r_run_cnt - RUN_W'(1);
                    end
                end
`ifdef CPU_LOADER_READBACK_EN
                DUMP_RD: begin
                    r_state <= DUMP_CAP;
                end
                DUMP_CAP: begin
                    r_m_data  <= rdata_ext_2;
                    r_m_valid <= 1'b1;
                    r_state   <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (w_last_d) begin
                            r_k     <= '0;
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k     <= w_k_inc;
                            r_state <= DUMP_RD;
                            r_ren2  <= 1'b1;
                            r_addr2 <= w_addr_d_next;
                        end
                    end
                end
`endif
                default: begin
                    r_state   <= IDLE;
                    r_s_ready <= 1'b0;
                    r_cpu_en  <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready     = r_s_ready;
    assign addr_ext    = r_addr;
    assign wen_ext     = r_wen;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = r_wdata;
    assign addr_ext_2  = r_addr2;
    assign wen_ext_2   = r_wen2;
    assign wdata_ext_2 = r_wdata2;
    assign cpu_enable  = r_cpu_en;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef CPU_LOADER_READBACK_EN
    assign ren_ext_2 = r_ren2;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
`else
    assign ren_ext_2 = 1'b0;
    assign m_valid   = 1'b0;
    assign m_data    = '0;
`endif

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: load, run, readback, zero counts, reset abort.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] imem_words, dmem_words;
    logic [31:0] run_cycles;
    logic        s_valid, s_ready;
    logic [63:0] s_data;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, m_data;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] rdata_ext_2;
    logic        cpu_enable, m_valid, m_ready, busy, done;

    always #5 clk = ~clk;

    cpu_loader #(.CNT_W(16), .RUN_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Data-memory model with one-cycle read latency
    logic [63:0] mem [0:15];
    assign rdata_ext = 32'h0;
    always @(posedge clk) begin
        if (wen_ext_2) mem[addr_ext_2[6:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[6:3]];
    end

    int          n_wen, n_wen2, n_ren2, n_en;
    logic [63:0] q_a[$], q_d[$], q_a2[$], q_r2[$];
    logic        conflict, rb_seen;

    always @(negedge clk) begin
        if (!rst) begin
            if (wen_ext)   begin n_wen++;  q_a.push_back(addr_ext); q_d.push_back({32'h0, wdata_ext}); end
            if (wen_ext_2) begin n_wen2++; q_a2.push_back(addr_ext_2); end
            if (ren_ext_2) begin n_ren2++; q_r2.push_back(addr_ext_2); end
            if (cpu_enable) n_en++;
            if ((wen_ext && wen_ext_2) || (cpu_enable && (wen_ext || wen_ext_2)) || ren_ext)
                conflict = 1'b1;
            if (m_valid || ren_ext_2 || (m_data != 64'h0)) rb_seen = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_wen = 0; n_wen2 = 0; n_ren2 = 0; n_en = 0;
        q_a.delete(); q_d.delete(); q_a2.delete(); q_r2.delete();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check(tag, done, 1);
    endtask

    logic [63:0] rb_exp [4];
    int          wc;

    initial begin
        rb_exp[0] = 64'h1111_2222_3333_4444;
        rb_exp[1] = 64'hA5A5_0000_FFFF_0001;
        rb_exp[2] = 64'h0000_0000_0000_0003;
        rb_exp[3] = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
        conflict = 1'b0; rb_seen = 1'b0;
        clear_mon();

        // Reset state
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        imem_words = '0; dmem_words = '0; run_cycles = '0;
        tick(); tick();
        check("rst s_ready", s_ready, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst cpu_enable", cpu_enable, 0);
        check("rst wen", {62'h0, wen_ext, wen_ext_2}, 0);
        check("rst readback", {62'h0, ren_ext_2, m_valid}, 0);
        check("rst addr", addr_ext | addr_ext_2 | m_data, 0);
        rst = 1'b0;
        tick();

        // Three instruction words, run 5
        clear_mon();
        imem_words = 16'd3; dmem_words = 16'd0; run_cycles = 32'd5;
        start = 1'b1; tick(); start = 1'b0;
        check("t1 s_ready", s_ready, 1);
        check("t1 busy", busy, 1);
        s_valid = 1'b1; s_data = 64'hFFFF_FFFF_0000_0013; tick();
        check("t1 wen0", wen_ext, 1);
        check("t1 addr0", addr_ext, 64'h0);
        check("t1 data0", wdata_ext, 32'h0000_0013);
        s_data = 64'hFFFF_FFFF_0010_0093; tick();
        check("t1 addr1", addr_ext, 64'h4);
        check("t1 data1", wdata_ext, 32'h0010_0093);
        s_data = 64'hFFFF_FFFF_0020_8113; tick();
        check("t1 addr2", addr_ext, 64'h8);
        check("t1 data2", wdata_ext, 32'h0020_8113);
        check("t1 s_ready low", s_ready, 0);
        s_valid = 1'b0;
        wc = 0;
        while (!cpu_enable && wc < 10) begin tick(); wc++; end
        check("t1 enable delay", wc, 1);
        wc = 0;
        while (cpu_enable && wc < 20) begin wc++; tick(); end
        check("t1 enable cycles", wc, 5);
        check("t1 done", done, 1);
        check("t1 busy end", busy, 0);
        check("t1 wen count", n_wen, 3);
        check("t1 wen2 count", n_wen2, 0);

        // Two data words with s_valid toggling
        clear_mon(); rb_seen = 1'b0;
        imem_words = 16'd0; dmem_words = 16'd2; run_cycles = 32'd2; m_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("t2 s_ready", s_ready, 1);
        check("t2 done cleared", done, 0);
        s_valid = 1'b0; s_data = 64'hDEAD_BEEF_0000_0001; tick();
        check("t2 no hs", wen_ext_2, 0);
        s_valid = 1'b1; tick();
        check("t2 wen2 0", wen_ext_2, 1);
        check("t2 addr2 0", addr_ext_2, 64'h0);
        check("t2 data2 0", wdata_ext_2, 64'hDEAD_BEEF_0000_0001);
        s_valid = 1'b0; s_data = 64'h2; tick();
        check("t2 no hs 2", wen_ext_2, 0);
        s_valid = 1'b1; tick();
        check("t2 wen2 1", wen_ext_2, 1);
        check("t2 addr2 1", addr_ext_2, 64'h8);
        check("t2 data2 1", wdata_ext_2, 64'h2);
        s_valid = 1'b0;
        wait_done("t2 done");
        check("t2 wen2 count", n_wen2, 2);
        check("t2 wen count", n_wen, 0);
        check("t2 enable count", n_en, 2);
`ifndef CPU_LOADER_READBACK_EN
        check("t2 no readback activity", rb_seen, 0);
`endif
        m_ready = 1'b0;

`ifdef CPU_LOADER_READBACK_EN
        // Four data words, readback with a stall on word 1
        clear_mon();
        imem_words = 16'd0; dmem_words = 16'd4; run_cycles = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin s_data = rb_exp[j]; tick(); end
        s_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wc = 0;
            while (!m_valid && wc < 10) begin tick(); wc++; end
            check("t3 m_valid", m_valid, 1);
            check("t3 m_data", m_data, rb_exp[j]);
            if (j == 1) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("t3 stall valid", m_valid, 1);
                    check("t3 stall data", m_data, rb_exp[1]);
                end
            end
            m_ready = 1'b1; tick(); m_ready = 1'b0;
            check("t3 valid drop", m_valid, 0);
        end
        check("t3 done", done, 1);
        check("t3 ren count", n_ren2, 4);
        for (int j = 0; j < 4; j++)
            if (j < q_r2.size()) check("t3 ren addr", q_r2[j], 64'(8 * j));
`endif

        // All counts zero
        clear_mon();
        imem_words = 16'd0; dmem_words = 16'd0; run_cycles = 32'd0;
        start = 1'b1; tick(); start = 1'b0;
        check("t4 busy", busy, 1);
        check("t4 done low", done, 0);
        tick();
        check("t4 done", done, 1);
        check("t4 busy end", busy, 0);
        tick();
        check("t4 no activity", n_wen + n_wen2 + n_ren2 + n_en, 0);

        // Reset during RUN
        clear_mon();
        run_cycles = 32'd10;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t5 enable", cpu_enable, 1);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5 rst enable", cpu_enable, 0);
        check("t5 rst busy", busy, 0);
        check("t5 rst done", done, 0);

        // start held during LOAD_I is ignored
        clear_mon();
        imem_words = 16'd2; dmem_words = 16'd0; run_cycles = 32'd1;
        start = 1'b1; tick();
        imem_words = 16'd5; dmem_words = 16'd3; run_cycles = 32'd7;
        s_valid = 1'b1; s_data = 64'h0000_0000_CAFE_0001; tick();
        start = 1'b0; s_data = 64'h0000_0000_CAFE_0002; tick();
        s_valid = 1'b0;
        wait_done("t6 done");
        check("t6 wen count", n_wen, 2);
        check("t6 enable count", n_en, 1);
        if (q_d.size() > 1) check("t6 data1", q_d[1], 64'hCAFE_0002);
        check("conflict", conflict, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
